instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/cpu_pkg.sv | 17 +
 rtl/sync_fifo2.sv | 53 +++++
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-side types: FSM state, buffer depth and the {pc, inst} entry.
package cpu_pkg;

   localparam int unsigned FETCH_DEPTH = 2;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDrain
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO with a synchronous clear; head is always visible on rdata.
module sync_fifo2
   import cpu_pkg::*;
#(
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [Width-1:0] wdata,
   input  logic             pop,
   output logic [Width-1:0] rdata,
   output logic [1:0]       count
);

   logic [Width-1:0] mem_q [FETCH_DEPTH];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             push_en;
   logic             pop_en;

   // Guard against overflow/underflow; a push into a full FIFO is allowed when it also pops.
   always_comb begin
      pop_en  = pop && (count_q != 2'd0);
      push_en = push && ((count_q != 2'd2) || pop_en);
   end

   // Storage, pointers and occupancy; clear empties the FIFO and zeroes the entries.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_en) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_en) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + 2'(push_en) - 2'(pop_en);
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: forwards fetch addresses to memory, pairs in-order responses with
// their addresses and buffers up to two instructions for decode. A flush drops in-flight work.
module instr_fetch_unit
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic        pc_valid,
   output logic        pc_ready,
   input  logic        flush,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        misalign
);

   localparam int unsigned EntryW = $bits(fetch_entry_t);

   fetch_state_t state_q, state_d;
   logic [1:0]   drop_q, drop_d;
   logic         misalign_q;

   // The tag FIFO holds exactly the outstanding requests, so its count is the outstanding count.
   logic [1:0]   outstanding;
   logic [1:0]   outstanding_nxt;
   logic [1:0]   buffered;
   logic [1:0]   in_flight;
   logic [1:0]   flush_drop;
   logic         credit_ok;
   logic         issue_ok;
   logic         accept;
   logic         rsp_take;
   logic         rsp_cnt;
   logic [31:0]  tag_head;
   logic [EntryW-1:0] out_head_raw;
   fetch_entry_t out_head;
   fetch_entry_t out_wdata;
   logic         inst_pop;

   // Request path, credit accounting and response steering.
   always_comb begin
      credit_ok       = ({1'b0, outstanding} + {1'b0, buffered}) < 3'd2;
      issue_ok        = credit_ok && (state_q != StDrain) && !flush && !rst;
      pc_ready        = imem_req_ready && issue_ok;
      imem_req_valid  = pc_valid && issue_ok;
      imem_req_addr   = pc_in;
      accept          = pc_valid && pc_ready;
      // Responses with nothing outstanding (e.g. after rst) are ignored.
      rsp_take        = imem_rsp_valid && (state_q != StDrain) && (outstanding != 2'd0) && !flush;
      in_flight       = outstanding + drop_q;
      rsp_cnt         = imem_rsp_valid && (in_flight != 2'd0);
      flush_drop      = in_flight - 2'(rsp_cnt);
      outstanding_nxt = outstanding + 2'(accept) - 2'(rsp_take);
      out_wdata.pc    = tag_head;
      out_wdata.inst  = imem_rsp_data;
      out_head        = fetch_entry_t'(out_head_raw);
      inst_valid      = (buffered != 2'd0);
      inst            = out_head.inst;
      inst_pc         = out_head.pc;
      inst_pop        = inst_valid && inst_ready;
   end

   // Next state and drop counter.
   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      if (flush) begin
         drop_d  = flush_drop;
         state_d = (flush_drop != 2'd0) ? StDrain : StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) state_d = StBusy;
            end
            StBusy: begin
               if (outstanding_nxt == 2'd0) state_d = StIdle;
            end
            StDrain: begin
               if (rsp_cnt) begin
                  drop_d = drop_q - 2'd1;
                  if (drop_q == 2'd1) state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State register and drop counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         drop_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   // Sticky misalignment flag; set on any presented address, accepted or not.
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else if (pc_valid && (pc_in[1:0] != 2'b00)) begin
         misalign_q <= 1'b1;
      end
   end

   assign misalign = misalign_q;

   sync_fifo2 #(
      .Width (32)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (flush),
      .push  (accept),
      .wdata (pc_in),
      .pop   (rsp_take),
      .rdata (tag_head),
      .count (outstanding)
   );

   sync_fifo2 #(
      .Width (EntryW)
   ) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (flush),
      .push  (rsp_take),
      .wdata (out_wdata),
      .pop   (inst_pop),
      .rdata (out_head_raw),
      .count (buffered)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with hand-computed expectations.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        pc_ready;
   logic        flush;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        misalign;

   int nvec;
   int nerr;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .pc_in          (pc_in),
      .pc_valid       (pc_valid),
      .pc_ready       (pc_ready),
      .flush          (flush),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .misalign       (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      rst = 1'b1;
      pc_in = 32'h10;
      pc_valid = 1'b1;
      flush = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      inst_ready = 1'b0;

      // Reset
      #1;
      chk("rst_pc_ready", pc_ready, 0);
      chk("rst_req_valid", imem_req_valid, 0);
      tick();
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst", inst, 0);
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_misalign", misalign, 0);
      rst = 1'b0;
      pc_valid = 1'b0;

      // Back-to-back 0x0, 0x4 with 1-cycle memory
      pc_valid = 1'b1; pc_in = 32'h0;
      #1;
      chk("b2b_req_valid", imem_req_valid, 1);
      chk("b2b_req_addr0", imem_req_addr, 32'h0);
      chk("b2b_pc_ready0", pc_ready, 1);
      tick();
      pc_in = 32'h4; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAAAA_0000;
      #1;
      chk("b2b_pc_ready1", pc_ready, 1);
      chk("b2b_no_bypass", inst_valid, 0);
      tick();
      pc_valid = 1'b0; imem_rsp_data = 32'hBBBB_0004; inst_ready = 1'b1;
      chk("b2b_valid0", inst_valid, 1);
      chk("b2b_pc0", inst_pc, 32'h0);
      chk("b2b_inst0", inst, 32'hAAAA_0000);
      tick();
      imem_rsp_valid = 1'b0;
      chk("b2b_valid1", inst_valid, 1);
      chk("b2b_pc1", inst_pc, 32'h4);
      chk("b2b_inst1", inst, 32'hBBBB_0004);
      tick();
      chk("b2b_empty", inst_valid, 0);
      inst_ready = 1'b0;

      // Backpressure: two buffered instructions block new requests
      pc_valid = 1'b1; pc_in = 32'h8;
      tick();
      pc_in = 32'hC; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_0008;
      #1;
      chk("bp_ready_one_out", pc_ready, 1);
      tick();
      pc_in = 32'h10; imem_rsp_data = 32'h1111_000C;
      #1;
      chk("bp_ready_credit", pc_ready, 0);
      chk("bp_req_blocked", imem_req_valid, 0);
      tick();
      imem_rsp_valid = 1'b0;
      #1;
      chk("bp_ready_full", pc_ready, 0);
      chk("bp_head_pc", inst_pc, 32'h8);
      tick();
      chk("bp_ready_hold", pc_ready, 0);
      chk("bp_head_inst", inst, 32'h1111_0008);
      chk("bp_head_valid", inst_valid, 1);
      pc_valid = 1'b0; inst_ready = 1'b1;
      #1;
      chk("bp_ready_pop_cycle", pc_ready, 0);
      tick();
      chk("bp_second_pc", inst_pc, 32'hC);
      chk("bp_second_inst", inst, 32'h1111_000C);
      chk("bp_ready_after_pop", pc_ready, 1);
      tick();
      chk("bp_empty", inst_valid, 0);
      inst_ready = 1'b0;

      // Flush with two outstanding: both responses dropped
      pc_valid = 1'b1; pc_in = 32'h20;
      tick();
      pc_in = 32'h24;
      tick();
      pc_valid = 1'b0; flush = 1'b1;
      #1;
      chk("fl2_pc_ready", pc_ready, 0);
      tick();
      flush = 1'b0; pc_valid = 1'b1; pc_in = 32'h40;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0020;
      #1;
      chk("fl2_drain_req0", imem_req_valid, 0);
      chk("fl2_drain_valid0", inst_valid, 0);
      tick();
      imem_rsp_data = 32'hDEAD_0024;
      #1;
      chk("fl2_drain_req1", imem_req_valid, 0);
      chk("fl2_drain_valid1", inst_valid, 0);
      tick();
      imem_rsp_valid = 1'b0;
      #1;
      chk("fl2_idle_req", imem_req_valid, 1);
      chk("fl2_idle_addr", imem_req_addr, 32'h40);
      chk("fl2_idle_valid", inst_valid, 0);
      tick();
      pc_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2222_0040;
      tick();
      imem_rsp_valid = 1'b0;
      chk("fl2_new_valid", inst_valid, 1);
      chk("fl2_new_pc", inst_pc, 32'h40);
      chk("fl2_new_inst", inst, 32'h2222_0040);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk("fl2_empty", inst_valid, 0);

      // Flush with a response in the same cycle: exactly one later response dropped
      pc_valid = 1'b1; pc_in = 32'h50;
      tick();
      pc_in = 32'h54;
      tick();
      pc_valid = 1'b0; flush = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0050;
      tick();
      flush = 1'b0; imem_rsp_data = 32'hDEAD_0054; pc_valid = 1'b1; pc_in = 32'h60;
      #1;
      chk("fl1_drain_req", imem_req_valid, 0);
      chk("fl1_drain_valid", inst_valid, 0);
      tick();
      imem_rsp_valid = 1'b0;
      #1;
      chk("fl1_idle_req", imem_req_valid, 1);
      chk("fl1_idle_valid", inst_valid, 0);
      tick();
      pc_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h3333_0060;
      tick();
      imem_rsp_valid = 1'b0;
      chk("fl1_new_pc", inst_pc, 32'h60);
      chk("fl1_new_inst", inst, 32'h3333_0060);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;

      // Flush with nothing outstanding: blocked that cycle only
      pc_valid = 1'b1; pc_in = 32'h80; flush = 1'b1;
      #1;
      chk("fl0_pc_ready", pc_ready, 0);
      chk("fl0_req_valid", imem_req_valid, 0);
      tick();
      flush = 1'b0;
      #1;
      chk("fl0_next_ready", pc_ready, 1);
      chk("fl0_next_req", imem_req_valid, 1);
      pc_valid = 1'b0;
      tick();

      // Misaligned address: forwarded unchanged, flag sticky
      pc_valid = 1'b1; pc_in = 32'h6;
      #1;
      chk("mis_before", misalign, 0);
      chk("mis_req_valid", imem_req_valid, 1);
      chk("mis_req_addr", imem_req_addr, 32'h6);
      tick();
      pc_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h4444_0006;
      chk("mis_set", misalign, 1);
      tick();
      imem_rsp_valid = 1'b0;
      chk("mis_pc", inst_pc, 32'h6);
      chk("mis_inst", inst, 32'h4444_0006);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk("mis_held", misalign, 1);
      chk("mis_empty", inst_valid, 0);

      // Reset while busy; late response ignored
      pc_valid = 1'b1; pc_in = 32'h70;
      tick();
      pc_valid = 1'b0; rst = 1'b1;
      #1;
      chk("rb_pc_ready_in_rst", pc_ready, 0);
      tick();
      rst = 1'b0;
      chk("rb_inst_valid", inst_valid, 0);
      chk("rb_inst", inst, 0);
      chk("rb_inst_pc", inst_pc, 0);
      chk("rb_misalign", misalign, 0);
      chk("rb_req_valid", imem_req_valid, 0);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h5555_0070;
      tick();
      imem_rsp_valid = 1'b0;
      chk("rb_late_ignored", inst_valid, 0);
      chk("rb_late_inst", inst, 0);
      chk("rb_credit_free", pc_ready, 1);
      tick();
      chk("rb_still_empty", inst_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
